// File: rtl/ip_pkg.sv
// Shared constants, header-field layout and checksum helper for the IPv4 transmit path.
package ip_pkg;

    localparam int HDR_LEN      = 22;
    localparam int HDR_BITS     = HDR_LEN * 8;
    localparam int IP_HDR_WORDS = 10;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  PROTO_ICMP     = 8'd1;
    localparam logic [7:0]  PROTO_UDP      = 8'd17;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [15:0] IP_HDR_BYTES   = 16'd20;

    // LSB positions of each field inside the header image; the image is sent MSB first
    localparam int OFS_ETHERTYPE = 160;
    localparam int OFS_VER_IHL   = 152;
    localparam int OFS_TOS       = 144;
    localparam int OFS_TOTAL_LEN = 128;
    localparam int OFS_IDENT     = 112;
    localparam int OFS_FLAGS     = 96;
    localparam int OFS_TTL       = 88;
    localparam int OFS_PROTOCOL  = 80;
    localparam int OFS_CHECKSUM  = 64;
    localparam int OFS_SRC_IP    = 32;
    localparam int OFS_DST_IP    = 0;

    typedef struct packed {
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] ident;
        logic [7:0]  protocol;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } hdr_fields_t;

    // Two end-around-carry folds bring a 20-bit sum of ten words back to 16 bits
    function automatic logic [15:0] fold_invert(input logic [19:0] sum);
        logic [16:0] fold1;
        logic [16:0] fold2;
        fold1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
        fold2 = {1'b0, fold1[15:0]} + {16'b0, fold1[16]};
        return ~fold2[15:0];
    endfunction

endpackage

// File: rtl/ip_hdr_checksum.sv
// Two-stage IPv4 header checksum pipeline: stage 1 sums the header words,
// stage 2 folds/inverts the sum and assembles the full 22-byte header image.
module ip_hdr_checksum
    import ip_pkg::*;
#(
    parameter logic [7:0]  TTL       = 8'd128,
    parameter bit          DF        = 1'b1,
    parameter logic [15:0] ETHERTYPE = ETHERTYPE_IPV4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          dscp,
    input  logic [7:0]          protocol,
    input  logic [15:0]         length,
    input  logic [15:0]         ip_id,
    input  logic [31:0]         local_ip,
    input  logic [31:0]         destination_ip,
    output logic [HDR_BITS-1:0] hdr_image,
    output logic                valid
);

    localparam logic [15:0] FLAGS_WORD = {1'b0, DF, 14'b0};

    hdr_fields_t         fields_comb;
    hdr_fields_t         fields_s1;
    logic [15:0]         words [IP_HDR_WORDS];
    logic [19:0]         sum_comb;
    logic [19:0]         sum_s1;
    logic                valid_s1;
    logic [HDR_BITS-1:0] image_comb;

    // Gather the live header fields and sum the ten header words (checksum word as zero)
    always_comb begin
        fields_comb.tos       = {dscp, 2'b00};
        fields_comb.total_len = IP_HDR_BYTES + length;
        fields_comb.ident     = ip_id;
        fields_comb.protocol  = protocol;
        fields_comb.src_ip    = local_ip;
        fields_comb.dst_ip    = destination_ip;

        words[0] = {IP_VER_IHL, fields_comb.tos};
        words[1] = fields_comb.total_len;
        words[2] = fields_comb.ident;
        words[3] = FLAGS_WORD;
        words[4] = {TTL, fields_comb.protocol};
        words[5] = 16'h0000;
        words[6] = fields_comb.src_ip[31:16];
        words[7] = fields_comb.src_ip[15:0];
        words[8] = fields_comb.dst_ip[31:16];
        words[9] = fields_comb.dst_ip[15:0];

        sum_comb = '0;
        for (int i = 0; i < IP_HDR_WORDS; i++) begin
            sum_comb = sum_comb + {4'b0, words[i]};
        end
    end

    // Stage 1 keeps the raw sum together with the fields it was computed from
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fields_s1 <= '0;
            sum_s1    <= '0;
            valid_s1  <= 1'b0;
        end else begin
            fields_s1 <= fields_comb;
            sum_s1    <= sum_comb;
            valid_s1  <= 1'b1;
        end
    end

    // Lay out the header image from the stage-1 fields and the finished checksum
    always_comb begin
        image_comb = '0;
        image_comb[OFS_ETHERTYPE +: 16] = ETHERTYPE;
        image_comb[OFS_VER_IHL   +: 8]  = IP_VER_IHL;
        image_comb[OFS_TOS       +: 8]  = fields_s1.tos;
        image_comb[OFS_TOTAL_LEN +: 16] = fields_s1.total_len;
        image_comb[OFS_IDENT     +: 16] = fields_s1.ident;
        image_comb[OFS_FLAGS     +: 16] = FLAGS_WORD;
        image_comb[OFS_TTL       +: 8]  = TTL;
        image_comb[OFS_PROTOCOL  +: 8]  = fields_s1.protocol;
        image_comb[OFS_CHECKSUM  +: 16] = fold_invert(sum_s1);
        image_comb[OFS_SRC_IP    +: 32] = fields_s1.src_ip;
        image_comb[OFS_DST_IP    +: 32] = fields_s1.dst_ip;
    end

    // Stage 2 registers the complete header image and its valid flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_image <= '0;
            valid     <= 1'b0;
        end else begin
            hdr_image <= image_comb;
            valid     <= valid_s1;
        end
    end

endmodule

// File: rtl/ipv4_tx_framer.sv
// IPv4 transmit framer: prepends EtherType and a 20-byte IPv4 header to a
// payload stream by pushing the payload through a 22-byte shift register.
module ipv4_tx_framer
    import ip_pkg::*;
#(
    parameter logic [7:0]  TTL          = 8'd128,
    parameter bit          DF           = 1'b1,
    parameter bit          ID_INCREMENT = 1'b1,
    parameter logic [15:0] ETHERTYPE    = 16'h0800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_enable,
    input  logic [7:0]  data_in,
    input  logic [7:0]  protocol,
    input  logic [5:0]  dscp,
    input  logic [15:0] length,
    input  logic [31:0] local_ip,
    input  logic [31:0] destination_ip,
    output logic        active,
    output logic [7:0]  data_out,
    output logic        ready,
    output logic [15:0] ip_id
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [4:0]  LAST_BYTE = 5'(HDR_LEN - 1);
    localparam logic [15:0] ID_STEP   = ID_INCREMENT ? 16'd1 : 16'd0;

    logic [1:0]          state;
    logic [4:0]          byte_no;
    logic [15:0]         ip_id_q;
    logic [15:0]         pipe_id;
    logic [HDR_BITS-1:0] shift_reg;
    logic [HDR_BITS-1:0] hdr_image;
    logic                pipe_valid;
    logic                pipe_valid_q;
    logic                idle_q;
    logic                sending;

    assign sending  = (state != ST_IDLE);
    assign active   = tx_enable | sending;
    assign data_out = shift_reg[HDR_BITS-1 -: 8];
    assign ready    = !sending && idle_q && pipe_valid_q;
    assign ip_id    = ip_id_q;

    // While a packet is in flight its header is already captured, so the
    // pipeline precomputes the next packet's header with the next ID value
    assign pipe_id = sending ? (ip_id_q + ID_STEP) : ip_id_q;

    ip_hdr_checksum #(
        .TTL       (TTL),
        .DF        (DF),
        .ETHERTYPE (ETHERTYPE)
    ) u_checksum (
        .clock          (clock),
        .reset          (reset),
        .dscp           (dscp),
        .protocol       (protocol),
        .length         (length),
        .ip_id          (pipe_id),
        .local_ip       (local_ip),
        .destination_ip (destination_ip),
        .hdr_image      (hdr_image),
        .valid          (pipe_valid)
    );

    // Packet state: SEND while payload arrives, FLUSH drains the last 22 bytes, then bump the ID
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            byte_no <= '0;
            ip_id_q <= '0;
        end else if (tx_enable) begin
            state   <= ST_SEND;
            byte_no <= LAST_BYTE;
        end else if (sending) begin
            if (byte_no == 5'd0) begin
                state   <= ST_IDLE;
                ip_id_q <= ip_id_q + ID_STEP;
            end else begin
                state   <= ST_FLUSH;
                byte_no <= byte_no - 5'd1;
            end
        end
    end

    // Idle: keep reloading the header image; active: shift out and append payload
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
        end else if (active) begin
            shift_reg <= {shift_reg[HDR_BITS-9:0], (tx_enable ? data_in : 8'h00)};
        end else begin
            shift_reg <= hdr_image;
        end
    end

    // Ready needs one settled idle cycle and a pipeline that has been valid a full cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_q       <= 1'b0;
            pipe_valid_q <= 1'b0;
        end else begin
            idle_q       <= !sending;
            pipe_valid_q <= pipe_valid;
        end
    end

endmodule

// File: tb/tb_ipv4_tx_framer.sv
// Scoreboard bench for ipv4_tx_framer: two instances (default parameters, and
// TTL=64/DF=0/no ID increment) see the same stimulus; expected bytes are queued
// when a packet is driven and popped whenever the DUT reports an active byte.
module tb_ipv4_tx_framer;
    import ip_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tx_enable = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  protocol = PROTO_UDP;
    logic [5:0]  dscp = 6'h00;
    logic [15:0] length = 16'd8;
    logic [31:0] local_ip = 32'hC0A8010A;
    logic [31:0] destination_ip = 32'hC0A80164;

    logic        active1, ready1, active2, ready2;
    logic [7:0]  data_out1, data_out2;
    logic [15:0] ip_id1, ip_id2;

    int          q1[$];
    int          q2[$];
    int          e1, e2;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_id1 = 16'h0000;
    logic [15:0] exp_id2 = 16'h0000;

    logic [7:0] golden [22] = '{8'h08, 8'h00, 8'h45, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00,
                                8'h40, 8'h00, 8'h80, 8'h11, 8'h77, 8'h12, 8'hC0, 8'hA8,
                                8'h01, 8'h0A, 8'hC0, 8'hA8, 8'h01, 8'h64};

    ipv4_tx_framer dut1 (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .data_in(data_in),
        .protocol(protocol), .dscp(dscp), .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .active(active1), .data_out(data_out1),
        .ready(ready1), .ip_id(ip_id1)
    );

    ipv4_tx_framer #(.TTL(8'd64), .DF(1'b0), .ID_INCREMENT(1'b0), .ETHERTYPE(16'h0800)) dut2 (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .data_in(data_in),
        .protocol(protocol), .dscp(dscp), .length(length), .local_ip(local_ip),
        .destination_ip(destination_ip), .active(active2), .data_out(data_out2),
        .ready(ready2), .ip_id(ip_id2)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference header built word by word with end-around carry on every add
    function automatic logic [HDR_BITS-1:0] modelHeader(input logic [7:0] ttl_v, input logic df_v,
                                                        input logic [15:0] id_v);
        logic [15:0] w [10];
        int unsigned s;
        w[0] = {8'h45, dscp, 2'b00};
        w[1] = 16'd20 + length;
        w[2] = id_v;
        w[3] = {1'b0, df_v, 14'b0};
        w[4] = {ttl_v, protocol};
        w[5] = 16'h0000;
        w[6] = local_ip[31:16];
        w[7] = local_ip[15:0];
        w[8] = destination_ip[31:16];
        w[9] = destination_ip[15:0];
        s = 0;
        for (int i = 0; i < 10; i++) begin
            s = s + w[i];
            if (s > 32'hFFFF) s = s - 32'hFFFF;
        end
        w[5] = ~s[15:0];
        return {16'h0800, w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8], w[9]};
    endfunction

    // Scoreboard: every active byte must match the next queued expectation (-1 = don't care)
    always @(negedge clock) begin
        if (active1) begin
            if (q1.size() == 0) checkOutput("dut1_extra_byte", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                if (e1 >= 0) checkOutput("dut1_byte", {24'd0, data_out1}, e1);
            end
        end
        if (active2) begin
            if (q2.size() == 0) checkOutput("dut2_extra_byte", 32'd1, 32'd0);
            else begin
                e2 = q2.pop_front();
                if (e2 >= 0) checkOutput("dut2_byte", {24'd0, data_out2}, e2);
            end
        end
    end

    task automatic checkReadyAfterReset();
        @(negedge clock);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            checkOutput("ready_after_reset_1", {31'd0, ready1}, (c == 3) ? 32'd1 : 32'd0);
            checkOutput("ready_after_reset_2", {31'd0, ready2}, (c == 3) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic waitReady(output bit ok);
        int cnt;
        repeat (3) @(posedge clock);
        cnt = 0;
        do begin
            @(posedge clock);
            #1;
            cnt++;
        end while (!(ready1 && ready2) && cnt < 200);
        ok = ready1 && ready2;
        if (!ok) checkOutput("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pushHeaders(input int nbytes, input bit use_golden);
        logic [HDR_BITS-1:0] h1, h2;
        h1 = modelHeader(8'd128, 1'b1, exp_id1);
        h2 = modelHeader(8'd64, 1'b0, exp_id2);
        for (int b = 0; b < nbytes; b++) begin
            q1.push_back(use_golden ? int'(golden[b]) : int'(h1[HDR_BITS-1-8*b -: 8]));
            q2.push_back(int'(h2[HDR_BITS-1-8*b -: 8]));
        end
    endtask

    task automatic drainAndCheck();
        int cnt;
        cnt = 0;
        while ((q1.size() != 0 || q2.size() != 0) && cnt < 200) begin
            @(posedge clock);
            cnt++;
        end
        if (cnt >= 200) begin
            checkOutput("drain_timeout", 32'd1, 32'd0);
            q1.delete();
            q2.delete();
        end
        #1;
        checkOutput("active_fall_1", {31'd0, active1}, 32'd0);
        checkOutput("active_fall_2", {31'd0, active2}, 32'd0);
        checkOutput("ready_low_1", {31'd0, ready1}, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("ready_rise_1", {31'd0, ready1}, 32'd1);
        checkOutput("ready_rise_2", {31'd0, ready2}, 32'd1);
    endtask

    // One packet: optional tx_enable gap of gap_len cycles before payload byte gap_after
    task automatic applyStimulus(input int nbytes, input logic [7:0] base, input int gap_after,
                                 input int gap_len, input bit use_golden);
        bit ok;
        waitReady(ok);
        if (!ok) return;
        pushHeaders(HDR_LEN, use_golden);
        for (int i = 0; i < nbytes; i++) begin
            if (gap_after > 0 && i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    q1.push_back(-1);
                    q2.push_back(-1);
                end
            end
            q1.push_back((int'(base) + i) & 255);
            q2.push_back((int'(base) + i) & 255);
        end
        for (int i = 0; i < nbytes; i++) begin
            if (gap_after > 0 && i == gap_after) begin
                tx_enable = 1'b0;
                data_in = 8'hEE;
                repeat (gap_len) begin
                    @(posedge clock);
                    #1;
                end
            end
            tx_enable = 1'b1;
            data_in = 8'((int'(base) + i) & 255);
            @(posedge clock);
            #1;
        end
        tx_enable = 1'b0;
        data_in = 8'h00;
        drainAndCheck();
        exp_id1 = exp_id1 + 16'd1;
        checkOutput("ip_id_1", {16'd0, ip_id1}, {16'd0, exp_id1});
        checkOutput("ip_id_2", {16'd0, ip_id2}, {16'd0, exp_id2});
    endtask

    task automatic resetMidPacket();
        bit ok;
        waitReady(ok);
        if (!ok) return;
        pushHeaders(11, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tx_enable = 1'b1;
            data_in = 8'(i);
            @(posedge clock);
            #1;
        end
        data_in = 8'd10;
        @(negedge clock);
        #1;
        reset = 1'b1;
        tx_enable = 1'b0;
        #1;
        checkOutput("rst_data_out_1", {24'd0, data_out1}, 32'd0);
        checkOutput("rst_active_1", {31'd0, active1}, 32'd0);
        checkOutput("rst_data_out_2", {24'd0, data_out2}, 32'd0);
        checkOutput("rst_active_2", {31'd0, active2}, 32'd0);
        checkOutput("rst_sb_left_1", q1.size(), 32'd0);
        checkOutput("rst_sb_left_2", q2.size(), 32'd0);
        q1.delete();
        q2.delete();
        exp_id1 = 16'h0000;
        exp_id2 = 16'h0000;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkReadyAfterReset();
        checkOutput("rst_ip_id_1", {16'd0, ip_id1}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] ipv4_tx_framer bench starting");
        #1;
        checkOutput("reset_active_1", {31'd0, active1}, 32'd0);
        checkOutput("reset_data_out_1", {24'd0, data_out1}, 32'd0);
        checkOutput("reset_ready_1", {31'd0, ready1}, 32'd0);
        checkOutput("reset_ip_id_1", {16'd0, ip_id1}, 32'd0);
        checkOutput("reset_active_2", {31'd0, active2}, 32'd0);
        checkOutput("reset_data_out_2", {24'd0, data_out2}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        checkReadyAfterReset();

        $display("[TB] packet A: reference UDP header, 8 bytes");
        applyStimulus(8, 8'h01, 0, 0, 1'b1);

        $display("[TB] packet B: second packet, next identification");
        applyStimulus(8, 8'h11, 0, 0, 1'b0);

        $display("[TB] packet C: ICMP, dscp 0x2E, tx_enable gap during flush");
        dscp = 6'h2E;
        protocol = PROTO_ICMP;
        length = 16'd6;
        applyStimulus(6, 8'h40, 3, 3, 1'b0);

        $display("[TB] packets D/E: identification wrap");
        dscp = 6'h00;
        protocol = PROTO_UDP;
        length = 16'd4;
        force dut1.ip_id_q = 16'hFFFF;
        @(posedge clock);
        #1;
        release dut1.ip_id_q;
        exp_id1 = 16'hFFFF;
        checkOutput("ip_id_preset", {16'd0, ip_id1}, {16'd0, exp_id1});
        applyStimulus(4, 8'hA0, 0, 0, 1'b0);
        applyStimulus(4, 8'hB0, 0, 0, 1'b0);

        $display("[TB] reset during header byte 10");
        local_ip = 32'h0A000001;
        destination_ip = 32'h0A0000FE;
        resetMidPacket();

        $display("[TB] packet F: after reset");
        applyStimulus(3, 8'hC0, 0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
